// File: rtl/switch_cfg_reg_bank.sv
// Configuration register bank for the chiplet switch: round-robin intake of
// switch-config flits, route-LUT / dateline storage and a read response port.
module switch_cfg_reg_bank #(
  parameter int         NUM_BUFFERS    = 4,
  parameter int         NUM_OUTPORTS   = 4,
  parameter int         NODE_ID_W      = 5,
  parameter int         LUT_DEPTH      = 16,
  parameter int         OUT_SEL_W      = $clog2(NUM_OUTPORTS),
  parameter int         ENTRY_W        = 1 + OUT_SEL_W + 2*NODE_ID_W,
  parameter logic [3:0] FMT_SWITCH_CFG = 4'hC,
  parameter int         PORT_W         = $clog2(NUM_BUFFERS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NODE_ID_W-1:0]         node_id,
  input  logic [NUM_BUFFERS-1:0]       in_valid,
  input  logic [NUM_BUFFERS*32-1:0]    in_payload,
  output logic [NUM_BUFFERS-1:0]       cfg_ready,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [13:0]                  rsp_data,
  output logic                         rsp_err,
  output logic [PORT_W-1:0]            rsp_port,
  output logic [LUT_DEPTH*ENTRY_W-1:0] route_lut,
  output logic [NUM_OUTPORTS-1:0]      dateline,
  output logic [7:0]                   err_cnt
);

  localparam logic [7:0] ADDR_DL = 8'h15;
  localparam logic [7:0] ADDR_EC = 8'h16;

  logic [ENTRY_W-1:0]     lut [LUT_DEPTH];
  logic [PORT_W-1:0]      ptr;
  logic [NUM_BUFFERS-1:0] req;
  logic [NUM_BUFFERS-1:0] elig;
  logic [NUM_BUFFERS-1:0] grant;
  logic [PORT_W-1:0]      gnt_idx;
  logic [PORT_W-1:0]      cand_idx;
  logic                   found;
  int                     cand;
  logic                   rsp_free;
  logic                   any_grant;
  logic [31:0]            sel_pl;
  logic                   sel_rd;
  logic [7:0]             sel_addr;
  logic [13:0]            sel_data;
  logic                   hit_lut;
  logic                   hit_dl;
  logic                   hit_ec;
  logic                   unmapped;
  logic [13:0]            rd_data;
  logic                   unused_bits;

  assign rsp_free = !rsp_valid || rsp_ready;

  always_comb begin
    req  = '0;
    elig = '0;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      req[i] = in_valid[i]
        && (in_payload[32*i+28 +: 4] == FMT_SWITCH_CFG)
        && (in_payload[32*i+23 +: NODE_ID_W] == node_id);
      // a read may only issue if the response slot frees this cycle
      elig[i] = req[i] && (!in_payload[32*i+22] || rsp_free);
    end
  end

  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    cand_idx = '0;
    found    = 1'b0;
    cand     = 0;
    for (int off = 1; off <= NUM_BUFFERS; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_BUFFERS)
        cand = cand - NUM_BUFFERS;
      cand_idx = PORT_W'(cand);
      if (!found && elig[cand_idx]) begin
        found   = 1'b1;
        gnt_idx = cand_idx;
      end
    end
    if (found && !rst)
      grant[gnt_idx] = 1'b1;
  end

  assign cfg_ready = grant;
  assign any_grant = |grant;

  always_comb begin
    sel_pl = '0;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      if (grant[i])
        sel_pl = in_payload[32*i +: 32];
    end
  end

  assign sel_rd   = sel_pl[22];
  assign sel_addr = sel_pl[21:14];
  assign sel_data = sel_pl[13:0];

  assign hit_lut  = (sel_addr != 8'h00)
                 && (sel_addr <= 8'(LUT_DEPTH));
  assign hit_dl   = (sel_addr == ADDR_DL);
  assign hit_ec   = (sel_addr == ADDR_EC);
  assign unmapped = !(hit_lut || hit_dl || hit_ec);

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      hit_lut: begin
        for (int k = 0; k < LUT_DEPTH; k++) begin
          if (sel_addr == 8'(k + 1))
            rd_data = 14'(lut[k]);
        end
      end
      hit_dl:  rd_data = 14'(dateline);
      hit_ec:  rd_data = 14'(err_cnt);
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= PORT_W'(NUM_BUFFERS - 1);
    else if (any_grant)
      ptr <= gnt_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LUT_DEPTH; k++)
        lut[k] <= '0;
    end else if (any_grant && !sel_rd) begin
      for (int k = 0; k < LUT_DEPTH; k++) begin
        if (sel_addr == 8'(k + 1))
          lut[k] <= sel_data[ENTRY_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dateline <= '0;
    else if (any_grant && !sel_rd && hit_dl)
      dateline <= sel_data[NUM_OUTPORTS-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cnt <= '0;
    else if (any_grant && unmapped && (err_cnt != 8'hFF))
      err_cnt <= err_cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      rsp_port  <= '0;
    end else if (any_grant && sel_rd) begin
      rsp_valid <= 1'b1;
      rsp_data  <= rd_data;
      rsp_err   <= unmapped;
      rsp_port  <= gnt_idx;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_flat
    assign route_lut[ENTRY_W*k +: ENTRY_W] = lut[k];
  end

  // payload bits outside the decoded fields for this configuration
  assign unused_bits = ^{in_payload, sel_data};

endmodule

// File: tb/tb_switch_cfg_reg_bank.sv
// Directed bench for switch_cfg_reg_bank with a read-response scoreboard.
module tb_switch_cfg_reg_bank;

  localparam int NB = 4;
  localparam int EW = 13;
  localparam logic [3:0] FMT = 4'hC;

  typedef struct packed {
    logic [13:0] data;
    logic        err;
    logic [1:0]  port;
  } rsp_t;

  logic           clk;
  logic           rst;
  logic [4:0]     node_id;
  logic [NB-1:0]  in_valid;
  logic [NB*32-1:0] in_payload;
  logic [NB-1:0]  cfg_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [13:0]    rsp_data;
  logic           rsp_err;
  logic [1:0]     rsp_port;
  logic [16*EW-1:0] route_lut;
  logic [3:0]     dateline;
  logic [7:0]     err_cnt;

  int checks = 0;
  int errors = 0;
  rsp_t sb[$];

  switch_cfg_reg_bank dut (
    .clk        (clk),
    .rst        (rst),
    .node_id    (node_id),
    .in_valid   (in_valid),
    .in_payload (in_payload),
    .cfg_ready  (cfg_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .rsp_port   (rsp_port),
    .route_lut  (route_lut),
    .dateline   (dateline),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] flit(input logic rd, input logic [4:0] dst,
                                       input logic [7:0] addr,
                                       input logic [13:0] data);
    return {FMT, dst, rd, addr, data};
  endfunction

  function automatic rsp_t mk(input logic [13:0] d, input logic e,
                              input logic [1:0] p);
    rsp_t r;
    r.data = d;
    r.err  = e;
    r.port = p;
    return r;
  endfunction

  function automatic logic [EW-1:0] ent(input int k);
    return route_lut[EW*k +: EW];
  endfunction

  task automatic put(input int b, input logic [31:0] f);
    in_valid[b] = 1'b1;
    in_payload[32*b +: 32] = f;
  endtask

  // response monitor: sampled on the falling edge, popped on handshake
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        chk("rsp", 32'({rsp_data, rsp_err, rsp_port}), 32'(sb[0]));
        if (rsp_ready)
          void'(sb.pop_front());
      end
    end
  end

  initial begin
    rst        = 1'b1;
    in_valid   = '0;
    in_payload = '0;
    rsp_ready  = 1'b0;
    node_id    = 5'd3;
    put(0, flit(1'b0, 5'd3, 8'h01, 14'h0111));
    repeat (2) tick();
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst_lut", 32'(|route_lut), 32'd0);
    chk("rst_dateline", 32'(dateline), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);

    put(2, flit(1'b0, 5'd3, 8'h02, 14'h0222));
    rst = 1'b0;
    #1;
    chk("prio_first", 32'(cfg_ready), 32'b0001);
    tick();
    in_valid[0] = 1'b0;
    #1;
    chk("prio_second", 32'(cfg_ready), 32'b0100);
    tick();
    in_valid = '0;
    #1;
    chk("lut_e0", 32'(ent(0)), 32'h0111);
    chk("lut_e1", 32'(ent(1)), 32'h0222);

    put(1, flit(1'b0, 5'd3, 8'h05, 14'h0A5B));
    #1;
    chk("wr_grant", 32'(cfg_ready), 32'b0010);
    tick();
    in_valid = '0;
    #1;
    chk("lut_e4", 32'(ent(4)), 32'h0A5B);
    rsp_ready = 1'b1;
    put(1, flit(1'b1, 5'd3, 8'h05, 14'h0));
    #1;
    chk("rd_grant", 32'(cfg_ready), 32'b0010);
    sb.push_back(mk(14'h0A5B, 1'b0, 2'd1));
    tick();
    in_valid = '0;
    #1;
    chk("rd_valid", 32'(rsp_valid), 32'd1);
    tick();
    chk("rd_clear", 32'(rsp_valid), 32'd0);

    put(2, flit(1'b0, 5'd3, 8'h10, 14'h3FFF));
    tick();
    in_valid = '0;
    #1;
    chk("lut_e15_mask", 32'(ent(15)), 32'h1FFF);
    put(2, flit(1'b1, 5'd3, 8'h10, 14'h0));
    sb.push_back(mk(14'h1FFF, 1'b0, 2'd2));
    tick();
    in_valid = '0;
    tick();

    put(3, flit(1'b0, 5'd3, 8'h15, 14'h3FFF));
    #1;
    chk("dl_grant", 32'(cfg_ready), 32'b1000);
    tick();
    in_valid = '0;
    #1;
    chk("dateline", 32'(dateline), 32'hF);
    put(0, flit(1'b0, 5'd4, 8'h01, 14'h0000));
    put(1, {4'h5, 5'd3, 1'b0, 8'h01, 14'h0000});
    #1;
    chk("foreign_no_grant", 32'(cfg_ready), 32'd0);
    tick();
    in_valid = '0;
    #1;
    chk("foreign_lut", 32'(ent(0)), 32'h0111);
    chk("foreign_err", 32'(err_cnt), 32'd0);
    put(3, flit(1'b1, 5'd3, 8'h15, 14'h0));
    sb.push_back(mk(14'h000F, 1'b0, 2'd3));
    tick();
    in_valid = '0;
    tick();

    for (int i = 0; i < NB; i++)
      put(i, flit(1'b0, 5'd3, 8'(8'h0A + i), 14'(14'h100 + i)));
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("fair", 32'(cfg_ready), 32'(1 << (k % NB)));
      tick();
    end
    in_valid = '0;
    #1;
    chk("fair_e9", 32'(ent(9)), 32'h0100);
    chk("fair_e12", 32'(ent(12)), 32'h0103);

    rsp_ready = 1'b0;
    put(2, flit(1'b1, 5'd3, 8'h01, 14'h0));
    #1;
    chk("bp_first_rd", 32'(cfg_ready), 32'b0100);
    sb.push_back(mk(14'h0111, 1'b0, 2'd2));
    tick();
    in_valid = '0;
    #1;
    put(0, flit(1'b1, 5'd3, 8'h02, 14'h0));
    put(1, flit(1'b0, 5'd3, 8'h03, 14'h0333));
    #1;
    chk("bp_write_wins", 32'(cfg_ready), 32'b0010);
    tick();
    in_valid[1] = 1'b0;
    #1;
    chk("bp_stall", 32'(cfg_ready), 32'd0);
    chk("bp_hold", 32'(rsp_data), 32'h0111);
    rsp_ready = 1'b1;
    #1;
    chk("bp_release", 32'(cfg_ready), 32'b0001);
    sb.push_back(mk(14'h0222, 1'b0, 2'd0));
    tick();
    in_valid = '0;
    #1;
    chk("bp_nobubble_v", 32'(rsp_valid), 32'd1);
    chk("bp_nobubble_d", 32'(rsp_data), 32'h0222);
    tick();
    chk("bp_drained", 32'(rsp_valid), 32'd0);
    chk("bp_lut_e2", 32'(ent(2)), 32'h0333);

    put(1, flit(1'b0, 5'd3, 8'h16, 14'h3FFF));
    tick();
    in_valid = '0;
    #1;
    chk("ec_wr_ignored", 32'(err_cnt), 32'd0);
    put(0, flit(1'b0, 5'd3, 8'h40, 14'h0));
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 253)
        chk("ec_fe", 32'(err_cnt), 32'hFE);
    end
    in_valid = '0;
    #1;
    chk("ec_sat", 32'(err_cnt), 32'hFF);
    put(0, flit(1'b1, 5'd3, 8'h40, 14'h0));
    sb.push_back(mk(14'h0000, 1'b1, 2'd0));
    tick();
    put(0, flit(1'b1, 5'd3, 8'h16, 14'h0));
    sb.push_back(mk(14'h00FF, 1'b0, 2'd0));
    tick();
    in_valid = '0;
    tick();
    chk("ec_sat_hold", 32'(err_cnt), 32'hFF);

    rsp_ready = 1'b0;
    put(3, flit(1'b1, 5'd3, 8'h01, 14'h0));
    sb.push_back(mk(14'h0111, 1'b0, 2'd3));
    tick();
    in_valid = '0;
    #1;
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    put(1, flit(1'b0, 5'd3, 8'h05, 14'h1234));
    #1;
    chk("pre_rst_grant", 32'(cfg_ready), 32'b0010);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(cfg_ready), 32'd0);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rsp", 32'({rsp_data, rsp_err, rsp_port}), 32'd0);
    chk("mid_rst_lut", 32'(|route_lut), 32'd0);
    chk("mid_rst_dl", 32'(dateline), 32'd0);
    chk("mid_rst_ec", 32'(err_cnt), 32'd0);
    sb.delete();
    tick();
    tick();
    in_valid = '0;
    put(0, flit(1'b0, 5'd3, 8'h01, 14'h0AAA));
    put(2, flit(1'b0, 5'd3, 8'h02, 14'h0BBB));
    rst = 1'b0;
    #1;
    chk("rst2_first", 32'(cfg_ready), 32'b0001);
    tick();
    in_valid[0] = 1'b0;
    #1;
    chk("rst2_second", 32'(cfg_ready), 32'b0100);
    tick();
    in_valid = '0;
    #1;
    chk("rst2_lost_wr", 32'(ent(4)), 32'd0);
    chk("rst2_e0", 32'(ent(0)), 32'h0AAA);
    chk("rst2_e1", 32'(ent(1)), 32'h0BBB);
    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_cfg_reg_bank.md
Name: switch_cfg_reg_bank

Overview:
- Parametrised configuration register bank for the chiplet switch.
- Accepts switch-configuration flits presented by NUM_BUFFERS input buffers and arbitrates them round-robin, one access per cycle.
- Writes route-LUT entries and the dateline register, and returns read responses through a valid/ready response port.
- Sits beside the route/arbitration logic. Feeds route_lut and dateline to the routing stage.

Parameters:
- NUM_BUFFERS, 4: input buffers that can present config flits.
- NUM_OUTPORTS, 4: output ports; this is the dateline width. Must be ≤14.
- NODE_ID_W, 5: node id width.
- LUT_DEPTH, 16: number of route-LUT entries. Range 1..20.
- OUT_SEL_W, $clog2(NUM_OUTPORTS): output-select field width.
- ENTRY_W, 1+OUT_SEL_W+2*NODE_ID_W: LUT entry width, laid out as {valid, out_sel, req, dest}. Must be ≤14.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous, active-high reset.
- node_id, input, NODE_ID_W: this switch's id. Quasi-static.
- in_valid, input, NUM_BUFFERS: a flit is present at buffer i.
- in_payload, input, NUM_BUFFERS*32: flit payloads, buffer i at [32i+31:32i].
- cfg_ready, output, NUM_BUFFERS: one-hot. The flit at buffer i is consumed this cycle.
- rsp_valid, output, 1: read response pending.
- rsp_ready, input, 1: consumer accepts the response.
- rsp_data, output, 14: read data, zero-extended.
- rsp_err, output, 1: the read hit an unmapped address.
- rsp_port, output, $clog2(NUM_BUFFERS): buffer that issued the read.
- route_lut, output, LUT_DEPTH*ENTRY_W: flattened LUT, entry k at [ENTRY_W*k +: ENTRY_W].
- dateline, output, NUM_OUTPORTS: dateline mask.
- err_cnt, output, 8: saturating count of unmapped-address accesses.

Behaviour:
- Payload decode:
  - fmt [31:28]
  - dest [27:23]; node ids narrower than 5 bits use the low bits.
  - rd [22]: 1 = read.
  - addr [21:14]
  - data [13:0]
- Request condition: buffer i requests when in_valid[i] && fmt==FMT_SWITCH_CFG && dest==node_id. Other flits are never acknowledged.
- Eligibility: a read request is eligible only if the response register is free (!rsp_valid) or draining (rsp_valid && rsp_ready). Write requests are always eligible.
- Arbitration:
  - Round-robin among eligible requests. A pointer holds the last-granted index.
  - Search starts at pointer+1 and wraps modulo NUM_BUFFERS.
  - The pointer updates only on a grant.
  - cfg_ready is combinational, at most one bit set. No grant when nothing is eligible.
- Address map:
  - 0x01..LUT_DEPTH: LUT entry addr-1, read/write, data[ENTRY_W-1:0]. Upper data bits are ignored on write and read as 0.
  - 0x15: dateline, read/write, data[NUM_OUTPORTS-1:0].
  - 0x16: err_cnt, read-only. Writes are ignored and not counted as errors.
  - Any other address (including 0x00): unmapped.
- Write: a granted write updates the target on the next clk edge. route_lut and dateline show the new value the cycle after the grant.
- Read: a granted read loads rsp_data, rsp_err and rsp_port and sets rsp_valid on the next edge, giving 1-cycle latency. The data is the register value before any same-cycle write, which cannot happen because there is one grant per cycle.
- Response handshake:
  - rsp_valid clears on rsp_valid && rsp_ready, unless a new read is granted in the same cycle, in which case the register reloads.
  - Outputs stay stable while rsp_valid && !rsp_ready.
- Unmapped access: the flit is still consumed. err_cnt increments and saturates at 0xFF. A read returns rsp_data=0 and rsp_err=1.
- Reset, asynchronous, sets:
  - route_lut all 0, so every valid bit is 0.
  - dateline 0, err_cnt 0.
  - rsp_valid 0, rsp_data 0, rsp_err 0, rsp_port 0.
  - RR pointer to NUM_BUFFERS-1, so buffer 0 has priority first.
  - Reset mid-transaction drops any pending response. A granted-but-unclocked write is lost.
- cfg_ready is 0 while rst is high.

Test Plan:
- Reset: assert rst mid-cycle with rsp_valid=1 → all outputs 0 immediately. After release, requests on buffers 0 and 2 in the same cycle → buffer 0 granted first, buffer 2 next cycle.
- LUT write/read: node_id=3, buffer 1 writes addr 0x05 data 0x0A5B → route_lut entry 4 = 0x0A5B & (2^ENTRY_W-1) one cycle later. A read of 0x05 → rsp_valid next cycle, rsp_data equal to that value, rsp_port=1.
- Dateline: write addr 0x15 data 0x3FFF with NUM_OUTPORTS=4 → dateline=4'hF. A flit with dest=4 ≠ node_id → cfg_ready stays 0 and nothing changes.
- Fairness: all 4 buffers hold writes continuously for 8 cycles → grants in order 0,1,2,3,0,1,2,3.
- Back-pressure: a read is pending with rsp_ready=0 and buffer 0 issues a read while buffer 1 issues a write → buffer 1 granted and buffer 0 stalled. Raising rsp_ready → buffer 0 granted in that cycle and the response reloads without a bubble.
- Errors: 300 writes to addr 0x40 → err_cnt saturates at 0xFF. A read of 0x40 → rsp_err=1, rsp_data=0. A read of 0x16 → rsp_data=0x0FF.
